// File: rtl/adc_sample_averager.sv
// ADC sample averager: accumulates blocks of 2^LOG2_N unsigned samples over a
// valid/ready handshake and publishes the truncated mean as a held word with a
// single-cycle valid strobe. Supports single-shot and continuous acquisition and
// aborts a block with a sticky error when the ADC stalls for TIMEOUT cycles.
module adc_sample_averager #(
    parameter int DATA_W  = 16,
    parameter int LOG2_N  = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              continuous,
    input  logic              smp_valid,
    input  logic [DATA_W-1:0] smp_data,
    output logic              smp_ready,
    output logic [DATA_W-1:0] adc_data,
    output logic              adc_valid,
    output logic              busy,
    output logic              timeout_err,
    output logic [LOG2_N:0]   sample_cnt
);

    // Sum of 2^LOG2_N samples of DATA_W bits fits in DATA_W+LOG2_N bits.
    localparam int ACC_W   = DATA_W + LOG2_N;
    localparam int STALL_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    // sample_cnt value held while the final sample of a block is being accepted
    localparam logic [LOG2_N:0]    LAST_IDX  = (LOG2_N + 1)'((1 << LOG2_N) - 1);
    // stall count that, with one more empty cycle, reaches TIMEOUT
    localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_next;
    logic [STALL_W-1:0] stall_cnt;
    logic               accept;

    // Truncating mean: drop the LOG2_N fractional bits, no rounding.
    function automatic logic [DATA_W-1:0] trunc_mean(input logic [ACC_W-1:0] sum);
        return DATA_W'(sum >> LOG2_N);
    endfunction

    assign smp_ready = (state == ACCUM);
    assign busy      = (state != IDLE);
    assign accept    = smp_valid && smp_ready;
    assign acc_next  = acc + ACC_W'(smp_data);

    // Block sequencing, accumulation, stall supervision and result publication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            stall_cnt   <= '0;
            sample_cnt  <= '0;
            adc_data    <= '0;
            adc_valid   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            adc_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= ACCUM;
                        acc         <= '0;
                        sample_cnt  <= '0;
                        stall_cnt   <= '0;
                        timeout_err <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc        <= acc_next;
                        sample_cnt <= sample_cnt + 1'b1;
                        stall_cnt  <= '0;
                        if (sample_cnt == LAST_IDX) begin
                            // final sample: publish mean computed from the
                            // sum including this sample
                            adc_data  <= trunc_mean(acc_next);
                            adc_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end else if (stall_cnt == STALL_LIM) begin
                        // ADC dead: abandon the block, keep the last result
                        timeout_err <= 1'b1;
                        stall_cnt   <= '0;
                        state       <= IDLE;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (continuous) begin
                        state      <= ACCUM;
                        acc        <= '0;
                        sample_cnt <= '0;
                        stall_cnt  <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sample_averager.sv
// Randomized self-checking bench for adc_sample_averager. A block-level
// reference model (plain integer mean of the accepted samples) predicts every
// published result; handshake timing is checked against the protocol rules.
module tb_adc_sample_averager;

    localparam int DATA_W  = 16;
    localparam int LOG2_N  = 3;
    localparam int NS      = 1 << LOG2_N;
    localparam int TIMEOUT = 16;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              continuous;
    logic              smp_valid;
    logic [DATA_W-1:0] smp_data;
    logic              smp_ready;
    logic [DATA_W-1:0] adc_data;
    logic              adc_valid;
    logic              busy;
    logic              timeout_err;
    logic [LOG2_N:0]   sample_cnt;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] blk [NS];
    logic [DATA_W-1:0] exp_data;
    logic [DATA_W-1:0] acc_q [$];

    adc_sample_averager #(
        .DATA_W (DATA_W),
        .LOG2_N (LOG2_N),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .continuous (continuous),
        .smp_valid  (smp_valid),
        .smp_data   (smp_data),
        .smp_ready  (smp_ready),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .busy       (busy),
        .timeout_err(timeout_err),
        .sample_cnt (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance one clock; inputs are driven and outputs observed 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] ref_mean();
        longint unsigned s = 0;
        for (int i = 0; i < NS; i++) s += blk[i];
        return DATA_W'(s / NS);
    endfunction

    task automatic start_block();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_ready", 32'(smp_ready), 32'd1);
    endtask

    // feed blk[] with random idle gaps of up to maxgap cycles, then check result
    task automatic run_block(input int maxgap, input bit chk_cnt);
        for (int i = 0; i < NS; i++) begin
            int gap = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
            for (int g = 0; g < gap; g++) begin
                smp_valid = 1'b0;
                smp_data  = DATA_W'($urandom);
                step();
                chk("gap_no_valid", 32'(adc_valid), 32'd0);
            end
            smp_valid = 1'b1;
            smp_data  = blk[i];
            step();
            if (chk_cnt) chk("sample_cnt", 32'(sample_cnt), 32'(i + 1));
            if (i < NS - 1) chk("early_valid", 32'(adc_valid), 32'd0);
        end
        smp_valid = 1'b0;
        exp_data  = ref_mean();
        chk("result_valid", 32'(adc_valid), 32'd1);
        chk("result_ready_low", 32'(smp_ready), 32'd0);
        chk("result_data", 32'(adc_data), 32'(exp_data));
        step();
        chk("after_valid", 32'(adc_valid), 32'd0);
        chk("after_busy", 32'(busy), 32'd0);
        chk("held_data", 32'(adc_data), 32'(exp_data));
    endtask

    initial begin
        int pulses;
        int accepted;
        int last_pulse;
        int k;

        rst_n      = 1'b0;
        start      = 1'b0;
        continuous = 1'b0;
        smp_valid  = 1'b0;
        smp_data   = '0;
        exp_data   = '0;
        step();
        step();

        chk("rst_data", 32'(adc_data), 32'd0);
        chk("rst_valid", 32'(adc_valid), 32'd0);
        chk("rst_ready", 32'(smp_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        chk("rst_cnt", 32'(sample_cnt), 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        // constant 0xAAAA, back to back
        for (int i = 0; i < NS; i++) blk[i] = 16'hAAAA;
        start_block();
        run_block(0, 1'b1);
        chk("aaaa_const", 32'(adc_data), 32'h0000AAAA);

        // ramp 0..7 with random valid gaps
        for (int i = 0; i < NS; i++) blk[i] = DATA_W'(i);
        start_block();
        run_block(4, 1'b1);
        chk("ramp_const", 32'(adc_data), 32'h00000003);

        // full scale without overflow, then minimum non-zero
        for (int i = 0; i < NS; i++) blk[i] = 16'hFFFF;
        start_block();
        run_block(2, 1'b0);
        chk("ffff_const", 32'(adc_data), 32'h0000FFFF);
        for (int i = 0; i < NS; i++) blk[i] = 16'h0001;
        start_block();
        run_block(2, 1'b0);
        chk("one_const", 32'(adc_data), 32'h00000001);

        // random blocks
        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < NS; i++) blk[i] = DATA_W'($urandom);
            start_block();
            run_block(5, 1'b1);
        end

        // stall timeout after 3 samples
        start_block();
        for (int i = 0; i < 3; i++) begin
            smp_valid = 1'b1;
            smp_data  = DATA_W'($urandom);
            step();
        end
        smp_valid = 1'b0;
        for (k = 1; k <= TIMEOUT; k++) begin
            smp_data = DATA_W'($urandom);
            step();
            chk("to_no_valid", 32'(adc_valid), 32'd0);
            if (k == TIMEOUT - 1) begin
                chk("to_err_early", 32'(timeout_err), 32'd0);
                chk("to_busy_early", 32'(busy), 32'd1);
            end
        end
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_idle", 32'(busy), 32'd0);
        chk("to_ready", 32'(smp_ready), 32'd0);
        chk("to_data_kept", 32'(adc_data), 32'(exp_data));
        step();
        chk("to_sticky", 32'(timeout_err), 32'd1);
        start_block();
        chk("to_cleared", 32'(timeout_err), 32'd0);
        for (int i = 0; i < NS; i++) blk[i] = DATA_W'($urandom);
        run_block(3, 1'b1);

        // continuous mode, 24 samples with valid held high
        continuous = 1'b1;
        start_block();
        acc_q.delete();
        pulses     = 0;
        accepted   = 0;
        last_pulse = -100;
        for (int cyc = 0; cyc < 60 && pulses < 3; cyc++) begin
            chk("cont_ready", 32'(smp_ready), 32'(!adc_valid));
            if (adc_valid) begin
                pulses++;
                if (pulses > 1) chk("cont_spacing", 32'(cyc - last_pulse), 32'd9);
                last_pulse = cyc;
                for (int i = 0; i < NS; i++) blk[i] = acc_q.pop_front();
                exp_data = ref_mean();
                chk("cont_data", 32'(adc_data), 32'(exp_data));
            end
            if (accepted < 3 * NS) begin
                smp_valid = 1'b1;
                smp_data  = DATA_W'($urandom);
                if (smp_ready) begin
                    acc_q.push_back(smp_data);
                    accepted++;
                    if (accepted == 3 * NS) continuous = 1'b0;
                end
            end else begin
                smp_valid = 1'b0;
            end
            step();
        end
        smp_valid = 1'b0;
        chk("cont_pulses", 32'(pulses), 32'd3);
        chk("cont_stop", 32'(busy), 32'd0);
        chk("cont_stop_valid", 32'(adc_valid), 32'd0);

        // asynchronous reset mid-block
        start_block();
        for (int i = 0; i < 5; i++) begin
            smp_valid = 1'b1;
            smp_data  = DATA_W'($urandom);
            step();
        end
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_data", 32'(adc_data), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(smp_ready), 32'd0);
        chk("arst_cnt", 32'(sample_cnt), 32'd0);
        chk("arst_valid", 32'(adc_valid), 32'd0);
        smp_valid = 1'b0;
        start     = 1'b1;
        step();
        chk("arst_start_ign", 32'(busy), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        step();
        chk("arst_idle", 32'(busy), 32'd0);
        for (int i = 0; i < NS; i++) blk[i] = 16'h0010;
        start_block();
        run_block(2, 1'b1);
        chk("arst_no_residue", 32'(adc_data), 32'h00000010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
